uart_tx_frame_shifter: RTL

UART_TX_FRAME_SHIFTER -- requirements
Module: uart_tx_frame_shifter

---
 rtl/uart_tx_frame_shifter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame_shifter.sv
// FIFO-buffered UART transmitter clocked by the baud tick: one BaudOut posedge per bit time.
// Frame = start, 5..DATA_W data bits LSB first, optional parity, one or two stop bits.
module uart_tx_frame_shifter #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              BaudOut,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr_en,
    input  logic [3:0]        data_bits,
    input  logic [1:0]        parity_type,
    input  logic              stop_bits,
    output logic              data_out,
    output logic              p_parity_out,
    output logic              tx_active,
    output logic              tx_done,
    output logic              full,
    output logic              empty,
    output logic              overflow
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_count;

    state_t            r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_nbits;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_par_en;
    logic              r_par_bit;
    logic              r_stop2;

    logic              w_push;
    logic              w_pop;
    logic              w_frame_end;
    logic              w_xor;
    logic [CNT_W-1:0]  w_nbits;
    logic [DATA_W-1:0] w_head_masked;
    logic [OCC_W-1:0]  w_count_nxt;

    // Out-of-range widths fall back to the full payload width.
    always_comb begin
        if ((data_bits < 4'd5) || (32'(data_bits) > DATA_W)) begin
            w_nbits = CNT_W'(DATA_W);
        end else begin
            w_nbits = CNT_W'(data_bits);
        end
    end

    always_comb begin
        w_head_masked = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (i < int'(w_nbits)) begin
                w_head_masked[i] = r_mem[r_rd_ptr][i];
            end
        end
    end

    assign w_xor       = ^w_head_masked;
    assign w_frame_end = (r_state == S_STOP) && !(r_stop2 && (r_cnt == CNT_W'(1)));
    assign w_pop       = !empty && ((r_state == S_IDLE) || w_frame_end);
    assign w_push      = wr_en && !full;
    assign w_count_nxt = r_count + OCC_W'(w_push) - OCC_W'(w_pop);

    always_ff @(posedge BaudOut) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers and flags; full/empty are registered from the next occupancy.
    always_ff @(posedge BaudOut or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            full    <= (w_count_nxt == OCC_W'(FIFO_DEPTH));
            empty   <= (w_count_nxt == '0);
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge BaudOut or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            data_out     <= 1'b1;
            p_parity_out <= 1'b0;
            tx_active    <= 1'b0;
            tx_done      <= 1'b0;
            r_shreg      <= '0;
            r_nbits      <= '0;
            r_cnt        <= '0;
            r_par_en     <= 1'b0;
            r_par_bit    <= 1'b0;
            r_stop2      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (w_pop) begin
                // Pop also covers the back-to-back case straight out of STOP.
                r_state      <= S_START;
                data_out     <= 1'b0;
                tx_active    <= 1'b1;
                tx_done      <= w_frame_end;
                r_shreg      <= w_head_masked;
                r_nbits      <= w_nbits;
                r_cnt        <= '0;
                r_par_en     <= (parity_type == 2'b01) || (parity_type == 2'b10);
                r_par_bit    <= (parity_type == 2'b01) ? ~w_xor : w_xor;
                r_stop2      <= stop_bits;
                p_parity_out <= ~w_xor;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        data_out     <= 1'b1;
                        tx_active    <= 1'b0;
                        p_parity_out <= 1'b0;
                    end
                    S_START: begin
                        data_out <= r_shreg[0];
                        r_shreg  <= r_shreg >> 1;
                        r_cnt    <= CNT_W'(1);
                        r_state  <= S_DATA;
                    end
                    S_DATA: begin
                        if (r_cnt == r_nbits) begin
                            if (r_par_en) begin
                                data_out <= r_par_bit;
                                r_state  <= S_PARITY;
                            end else begin
                                data_out <= 1'b1;
                                r_cnt    <= CNT_W'(1);
                                r_state  <= S_STOP;
                            end
                        end else begin
                            data_out <= r_shreg[0];
                            r_shreg  <= r_shreg >> 1;
                            r_cnt    <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_PARITY: begin
                        data_out <= 1'b1;
                        r_cnt    <= CNT_W'(1);
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        if (w_frame_end) begin
                            tx_done      <= 1'b1;
                            data_out     <= 1'b1;
                            tx_active    <= 1'b0;
                            p_parity_out <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            data_out <= 1'b1;
                            r_cnt    <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        data_out  <= 1'b1;
                        tx_active <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
